qdiv_issue: RTL and testbench

- Operand-issue and result-capture stage that sits directly upstream of qdiv, the sequential Q-format signed-magnitude divider, and feeds it.
- Buffers dividend/divisor pairs from the datapath in a small FIFO and issues them to qdiv one at a time with a single-cycle start pulse.
- Tracks qdiv's done level, handles divide-by-zero and hang (timeout), and presents each result on a valid/ready output port.

---
 rtl/qdiv_issue.sv | 153 +++++++++++++++
 tb/tb_qdiv_issue.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qdiv_issue.sv
// qdiv_issue: operand FIFO, start/done sequencing and result register for qdiv.
// Ports: in_* operand push, div_* qdiv handshake, out_* result, busy/fifo_count status.
module qdiv_issue #(
    parameter int N       = 32,
    parameter int Q       = 15,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_dividend,
    input  logic [N-1:0]               in_divisor,
    output logic [N-1:0]               div_dividend,
    output logic [N-1:0]               div_divisor,
    output logic                       div_start,
    input  logic                       div_done,
    input  logic [N-1:0]               div_quotient,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out_quotient,
    output logic                       out_dz,
    output logic                       out_timeout,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    // Q only describes the operand format; reject configurations qdiv cannot run.
    if (Q >= N - 1 || TIMEOUT <= N + Q + 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0)
    begin : g_bad_cfg
        $error("qdiv_issue: illegal N/Q/DEPTH/TIMEOUT");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t        state;
    logic [N-1:0]  dvd_mem [DEPTH];
    logic [N-1:0]  dvs_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [TW-1:0] tmo;

    logic          push;
    logic          pop;
    logic [N-1:0]  head_dvd;
    logic [N-1:0]  head_dvs;
    logic          head_dz;
    logic          expired;

    assign in_ready   = (count < CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = (state == IDLE) && (count != '0) && !out_valid;
    assign head_dvd   = dvd_mem[rd_ptr];
    assign head_dvs   = dvs_mem[rd_ptr];
    assign head_dz    = (head_dvs[N-2:0] == '0);
    assign expired    = (tmo >= TW'(TIMEOUT));
    assign fifo_count = count;
    assign busy       = (state != IDLE) || (count != '0) || out_valid;

    // Storage needs no reset: occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            dvd_mem[wr_ptr] <= in_dividend;
            dvs_mem[wr_ptr] <= in_divisor;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tmo          <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            div_start    <= 1'b0;
            out_valid    <= 1'b0;
            out_quotient <= '0;
            out_dz       <= 1'b0;
            out_timeout  <= 1'b0;
        end else begin
            div_start <= 1'b0;
            if (out_valid && out_ready) out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        if (head_dz) begin
                            // Zero divisor: saturate magnitude, keep sign, skip qdiv.
                            out_quotient <= {head_dvd[N-1] ^ head_dvs[N-1], {(N-1){1'b1}}};
                            out_dz       <= 1'b1;
                            out_timeout  <= 1'b0;
                            out_valid    <= 1'b1;
                        end else begin
                            div_dividend <= head_dvd;
                            div_divisor  <= head_dvs;
                            div_start    <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    tmo   <= TW'(1);
                    state <= WAIT_ACK;
                end
                WAIT_ACK, WAIT_DONE: begin
                    tmo <= tmo + 1'b1;
                    if (expired) begin
                        out_quotient <= '0;
                        out_dz       <= 1'b0;
                        out_timeout  <= 1'b1;
                        out_valid    <= 1'b1;
                        state        <= IDLE;
                    end else if (state == WAIT_ACK) begin
                        if (!div_done) state <= WAIT_DONE;
                    end else if (div_done) begin
                        out_quotient <= div_quotient;
                        out_dz       <= 1'b0;
                        out_timeout  <= 1'b0;
                        out_valid    <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qdiv_issue.sv
// tb_qdiv_issue: directed + randomized bench for qdiv_issue with a behavioural qdiv.
// Results are checked against a scoreboard of quotients computed from the operands.
module tb_qdiv_issue;

    localparam int N       = 32;
    localparam int Q       = 15;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int CW      = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_dividend;
    logic [N-1:0]  in_divisor;
    logic [N-1:0]  div_dividend;
    logic [N-1:0]  div_divisor;
    logic          div_start;
    logic          div_done = 1'b1;
    logic [N-1:0]  div_quotient = '0;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_quotient;
    logic          out_dz;
    logic          out_timeout;
    logic          busy;
    logic [CW-1:0] fifo_count;

    qdiv_issue #(.N(N), .Q(Q), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_start    (div_start),
        .div_done     (div_done),
        .div_quotient (div_quotient),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quotient (out_quotient),
        .out_dz       (out_dz),
        .out_timeout  (out_timeout),
        .busy         (busy),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Sign-magnitude Q-format quotient, magnitude truncated to N-1 bits.
    function automatic logic [N-1:0] qref(input logic [N-1:0] a, input logic [N-1:0] b);
        longint unsigned am;
        longint unsigned bm;
        longint unsigned qq;
        am = longint'(a[N-2:0]);
        bm = longint'(b[N-2:0]);
        qq = (am << Q) / bm;
        return {a[N-1] ^ b[N-1], qq[N-2:0]};
    endfunction

    // Behavioural qdiv: done drops the cycle after start, rises 46 cycles later.
    logic         hang = 1'b0;
    int           rem  = 0;
    logic [N-1:0] m_a  = '0;
    logic [N-1:0] m_b  = '0;

    always @(posedge clk) begin
        if (div_start && !hang) begin
            div_done <= 1'b0;
            rem      <= 45;
            m_a      <= div_dividend;
            m_b      <= div_divisor;
        end else if (!div_done) begin
            if (rem == 0) begin
                div_done     <= 1'b1;
                div_quotient <= qref(m_a, m_b);
            end else begin
                rem <= rem - 1;
            end
        end
    end

    // Start-pulse bookkeeping and operand stability while an op is in flight.
    int           nstart   = 0;
    int           consec   = 0;
    int           stab_err = 0;
    logic         prev_st  = 1'b0;
    logic         trk      = 1'b0;
    logic [N-1:0] sa       = '0;
    logic [N-1:0] sdv      = '0;

    always @(negedge clk) begin
        prev_st <= div_start;
        if (div_start) nstart <= nstart + 1;
        if (div_start && prev_st) consec <= consec + 1;
        if (!rst_n) begin
            trk <= 1'b0;
        end else if (div_start) begin
            trk <= 1'b1;
            sa  <= div_dividend;
            sdv <= div_divisor;
        end else if (trk) begin
            if (div_dividend !== sa || div_divisor !== sdv) stab_err <= stab_err + 1;
            if (out_valid) trk <= 1'b0;
        end
    end

    typedef struct {
        logic [N-1:0] q;
        logic         dz;
        logic         to;
        int           t;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic push(input logic [N-1:0] a, input logic [N-1:0] b);
        int   w;
        exp_t e;
        w           = 0;
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        while (in_ready !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        e.dz = (b[N-2:0] == '0);
        e.to = hang && !e.dz;
        e.q  = e.dz ? {a[N-1] ^ b[N-1], {(N-1){1'b1}}} : (e.to ? '0 : qref(a, b));
        e.t  = cyc;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(output int lat);
        int   w;
        exp_t e;
        w   = 0;
        e.q = '0; e.dz = 1'b0; e.to = 1'b0; e.t = cyc;
        while (out_valid !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("out_valid_wait", 64'(out_valid), 64'd1);
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) e = sb.pop_front();
        lat = cyc - e.t;
        chk("out_quotient", 64'(out_quotient), 64'(e.q));
        chk("out_dz", 64'(out_dz), 64'(e.dz));
        chk("out_timeout", 64'(out_timeout), 64'(e.to));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic logic [N-1:0] rnd_a();
        logic [N-1:0] a;
        a          = $urandom;
        a[N-2:20]  = '0;
        return a;
    endfunction

    function automatic logic [N-1:0] rnd_b(input bit allow_dz);
        logic [N-1:0] b;
        b         = $urandom;
        b[N-2:16] = '0;
        if (b[N-2:0] == '0) b[8] = 1'b1;
        if (allow_dz && $urandom_range(0, 3) == 0) b[N-2:0] = '0;
        return b;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int lat;
    int ns0;
    int ov_seen;

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_ready   = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_div_start", 64'(div_start), 64'd0);
        chk("rst_out_quotient", 64'(out_quotient), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 3.0 / 1.5
        push(32'h0001_8000, 32'h0000_C000);
        collect(lat);
        chk("lat_normal", 64'(lat), 64'd50);
        chk("start_count_1", 64'(nstart), 64'd1);
        chk("busy_after_ack", 64'(busy), 64'd0);

        // -3.0 / 1.5
        push(32'h8001_8000, 32'h0000_C000);
        collect(lat);
        chk("start_count_2", 64'(nstart), 64'd2);
        chk("issued_dividend", 64'(sa), 64'h8001_8000);
        chk("issued_divisor", 64'(sdv), 64'h0000_C000);
        chk("operand_stable", 64'(stab_err), 64'd0);

        // divide by -0
        push(32'h0001_8000, 32'h8000_0000);
        collect(lat);
        chk("lat_dz", 64'(lat), 64'd2);
        chk("start_count_dz", 64'(nstart), 64'd2);

        // Backpressure: a parked result blocks issue while the FIFO fills.
        push(32'h0000_0005, 32'h0000_0000);
        for (int i = 0; i < 4; i++) push(rnd_a(), rnd_b(1'b1));
        chk("full_fifo_count", 64'(fifo_count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        fork
            push(rnd_a(), rnd_b(1'b1));
            begin
                repeat (3) @(negedge clk);
                chk("held_fifo_count", 64'(fifo_count), 64'd4);
                chk("held_in_ready", 64'(in_ready), 64'd0);
                for (int i = 0; i < 6; i++) collect(lat);
            end
        join
        chk("bp_sb_drained", 64'(sb.size()), 64'd0);

        // Hung qdiv: both entries time out, the second still issues.
        hang = 1'b1;
        ns0  = nstart;
        push(32'h0001_8000, 32'h0000_C000);
        push(32'h0002_0000, 32'h0001_0000);
        collect(lat);
        chk("lat_timeout", 64'(lat), 64'(TIMEOUT + 3));
        collect(lat);
        chk("start_count_to", 64'(nstart), 64'(ns0 + 2));
        hang = 1'b0;

        // Random pairs, one at a time.
        for (int i = 0; i < 6; i++) begin
            push(rnd_a(), rnd_b(1'b1));
            collect(lat);
        end

        // Reset while an op is in WAIT_DONE with two entries queued.
        push(rnd_a(), rnd_b(1'b0));
        push(rnd_a(), rnd_b(1'b0));
        push(rnd_a(), rnd_b(1'b0));
        repeat (8) @(negedge clk);
        chk("pre_rst_fifo_count", 64'(fifo_count), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_div_start", 64'(div_start), 64'd0);
        chk("mid_rst_div_dividend", 64'(div_dividend), 64'd0);
        chk("mid_rst_div_divisor", 64'(div_divisor), 64'd0);
        chk("mid_rst_out_quotient", 64'(out_quotient), 64'd0);
        chk("mid_rst_flags", 64'({out_dz, out_timeout}), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_fifo_count", 64'(fifo_count), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        sb.delete();
        ns0     = nstart;
        ov_seen = 0;
        repeat (120) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        chk("no_result_after_rst", 64'(ov_seen), 64'd0);
        chk("no_start_after_rst", 64'(nstart), 64'(ns0));
        chk("no_consec_start", 64'(consec), 64'd0);
        chk("operand_stable_all", 64'(stab_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
